rr_arbiter32: RTL

- Round-robin arbiter that shares one resource (a bus or peripheral slot) among 32 requesters.
- Outputs the owner as a 5-bit index and as a one-hot 32-bit grant vector; the one-hot vector is the same shape a 5-to-32 decoder produces.
- Enforces a maximum hold time per owner.
- Places one dead cycle between consecutive owners.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 39 +++
 rtl/rr_arbiter32.sv | 125 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared constants and types for the 32-way round-robin arbiter.
//   N       : number of requesters (fixed at 32)
//   IDX_W   : width of a requester index (log2(N))
//   HOLD_W  : width of the per-owner hold counter (MAX_HOLD up to 255)
//   state_t : arbiter FSM states
//   idx_to_onehot : index-to-one-hot expansion (5-to-32 decoder shape)
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int N      = 32;
    localparam int IDX_W  = 5;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin search. Finds the first set bit of req
//   scanning upward from (last+1) mod 32, wrapping 31 -> 0.
//   Ports:
//     req     in  [31:0] request vector
//     last    in  [4:0]  index of the most recent winner
//     any     out        at least one request is present
//     win_idx out [4:0]  index of the winner (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] start;

    assign start = last + IDX_W'(1);

    // Scan offsets from farthest to nearest; the nearest set bit is written
    // last and therefore wins. Index arithmetic wraps naturally in IDX_W bits.
    always_comb begin
        logic [IDX_W-1:0] cand;
        any     = |req;
        win_idx = '0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter32.sv
// ---------------------------------------------------------------------------
// rr_arbiter32
//   Round-robin arbiter sharing one resource among 32 requesters. Each owner
//   may hold the grant for at most MAX_HOLD cycles, and one dead cycle is
//   always inserted between consecutive owners. All outputs are registered.
//   Ports:
//     clk         in         rising-edge clock
//     rst         in         synchronous, active-high reset
//     req         in  [31:0] level-sensitive request per requester
//     release_gnt in         current owner finished (sampled only in GRANT);
//                            named release_gnt because "release" is a
//                            reserved word in SystemVerilog
//     gnt         out [31:0] one-hot grant, zero when no owner
//     gnt_idx     out [4:0]  index of current owner, zero when no owner
//     gnt_valid   out        a grant is active
//     timeout     out        one-cycle pulse when MAX_HOLD revokes a grant
// ---------------------------------------------------------------------------
module rr_arbiter32
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             release_gnt,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [IDX_W-1:0]    last_q,  last_d;
    logic [N-1:0]        gnt_d;
    logic [IDX_W-1:0]    gnt_idx_d;
    logic                gnt_valid_d;
    logic                timeout_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    logic                owner_drop;
    logic                at_limit;

    rr_pick u_pick (
        .req     (req),
        .last    (last_q),
        .any     (pick_any),
        .win_idx (pick_idx)
    );

    // Next-state and next-output logic. Outputs default to "no owner" so
    // every exit from GRANT produces the idle pattern automatically.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_d      = last_q;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;
        owner_drop  = 1'b0;
        at_limit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    hold_d      = '0;
                    last_d      = pick_idx;
                    gnt_d       = idx_to_onehot(pick_idx);
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                end
            end

            GRANT: begin
                // Only the owner's own request bit matters while granted.
                owner_drop = ~req[gnt_idx];
                at_limit   = (hold_q == HOLD_W'(MAX_HOLD - 1));
                if (release_gnt || owner_drop || at_limit) begin
                    state_d   = IDLE;
                    hold_d    = '0;
                    // A voluntary end in the same cycle masks the timeout.
                    timeout_d = at_limit && !release_gnt && !owner_drop;
                end else begin
                    hold_d      = hold_q + HOLD_W'(1);
                    gnt_d       = gnt;
                    gnt_idx_d   = gnt_idx;
                    gnt_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. last resets to 31 so requester 0 is
    // searched first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            last_q    <= IDX_W'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule
